// File: rtl/mac_accumulator_8bit_if.sv
// Handshake and data bundle for the 8-bit MAC accumulator.
//   start/len       : run request and product count (upstream -> block)
//   P/in_valid      : product stream from the 8x8 multiplier (upstream -> block)
//   in_ready        : block accepts P this cycle (block -> upstream)
//   ACC/overflow    : accumulated result and sticky saturation flag (block -> downstream)
//   out_valid       : ACC/overflow hold a final result (block -> downstream)
//   out_ready       : downstream consumes the result (downstream -> block)
//   busy            : block is not idle
interface mac_accumulator_8bit_if #(
  parameter int unsigned ACC_W = 18,
  parameter int unsigned LEN_W = 4
) ();
  logic             start;
  logic [LEN_W-1:0] len;
  logic [15:0]      P;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] ACC;
  logic             overflow;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  // Requester side: issues runs, supplies products, consumes results.
  modport master (
    output start, len, P, in_valid, out_ready,
    input  in_ready, ACC, overflow, out_valid, busy
  );

  // Accumulator side.
  modport slave (
    input  start, len, P, in_valid, out_ready,
    output in_ready, ACC, overflow, out_valid, busy
  );
endinterface

// File: rtl/mac_accumulator_8bit.sv
// Saturating accumulator for a run of unsigned 16-bit products.
// A start in IDLE clears the result and loads the product count; each accepted
// product is added with saturation at 2^ACC_W-1; after the last product the
// result is presented until out_ready.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of mac_accumulator_8bit_if (start/len, P stream, result)
module mac_accumulator_8bit #(
  parameter int unsigned ACC_W = 18,
  parameter int unsigned LEN_W = 4
) (
  input logic                  clk,
  input logic                  rst,
  mac_accumulator_8bit_if.slave bus
);

  localparam int unsigned PadW = ACC_W + 1 - 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [LEN_W-1:0] rem_q, rem_d;

  // One extra bit so the carry flags saturation instead of wrapping.
  logic [ACC_W:0]   sum;

  always_comb begin
    sum     = {1'b0, acc_q} + {{PadW{1'b0}}, bus.P};
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    rem_d   = rem_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (bus.len != '0) begin
            rem_d   = bus.len;
            state_d = StAccum;
          end else begin
            state_d = StDone;
          end
        end
      end
      StAccum: begin
        if (bus.in_valid) begin
          if (sum[ACC_W]) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum[ACC_W-1:0];
          end
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      rem_q   <= rem_d;
    end
  end

  // Outputs decode from registered state only.
  assign bus.in_ready  = (state_q == StAccum);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.ACC       = acc_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_mac_accumulator_8bit.sv
module tb_mac_accumulator_8bit;

  localparam int unsigned AccW = 18;
  localparam int unsigned LenW = 4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mac_accumulator_8bit_if #(.ACC_W(AccW), .LEN_W(LenW)) bus ();

  mac_accumulator_8bit #(.ACC_W(AccW), .LEN_W(LenW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string               name;
    logic [LenW-1:0]     len;
    logic [4:0][15:0]    p;
    int                  gap;
    int                  stall;
    logic [AccW-1:0]     exp_acc;
    logic                exp_ovf;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [AccW:0]   m;
    logic [AccW-1:0] model;
    logic            movf;
    model = '0;
    movf  = 1'b0;
    bus.start = 1'b1;
    bus.len   = v.len;
    tick();
    bus.start = 1'b0;
    bus.len   = '0;
    chk({v.name, "_busy"}, 32'(bus.busy), 32'd1);
    for (int k = 0; k < int'(v.len); k++) begin
      for (int g = 0; g < v.gap; g++) begin
        tick();
        chk({v.name, "_gap_acc"}, 32'(bus.ACC), 32'(model));
        chk({v.name, "_gap_ready"}, 32'(bus.in_ready), 32'd1);
      end
      chk({v.name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.P        = v.p[k];
      tick();
      bus.in_valid = 1'b0;
      bus.P        = '0;
      m = {1'b0, model} + {{(AccW + 1 - 16){1'b0}}, v.p[k]};
      if (m[AccW]) begin
        model = '1;
        movf  = 1'b1;
      end else begin
        model = m[AccW-1:0];
      end
      chk({v.name, "_acc_step"}, 32'(bus.ACC), 32'(model));
      chk({v.name, "_out_valid_step"}, 32'(bus.out_valid), 32'(k == int'(v.len) - 1));
    end
    chk({v.name, "_acc"}, 32'(bus.ACC), 32'(v.exp_acc));
    chk({v.name, "_ovf"}, 32'(bus.overflow), 32'(v.exp_ovf));
    chk({v.name, "_ovf_model"}, 32'(bus.overflow), 32'(movf));
    for (int s = 0; s < v.stall; s++) begin
      tick();
      chk({v.name, "_stall_valid"}, 32'(bus.out_valid), 32'd1);
      chk({v.name, "_stall_acc"}, 32'(bus.ACC), 32'(v.exp_acc));
      chk({v.name, "_stall_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({v.name, "_drain_valid"}, 32'(bus.out_valid), 32'd0);
    chk({v.name, "_drain_busy"}, 32'(bus.busy), 32'd0);
    chk({v.name, "_idle_acc"}, 32'(bus.ACC), 32'(v.exp_acc));
    chk({v.name, "_idle_ovf"}, 32'(bus.overflow), 32'(v.exp_ovf));
  endtask

  initial begin
    vec_t tmp;
    errors = 0;
    checks = 0;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.P         = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    vecs[0] = '{"basic", 4'd3, {16'd0, 16'd0, 16'd14450, 16'd3600, 16'd125}, 0, 0,
                18'd18175, 1'b0};
    vecs[1] = '{"stall", 4'd3, {16'd0, 16'd0, 16'd14450, 16'd3600, 16'd125}, 2, 5,
                18'd18175, 1'b0};
    vecs[2] = '{"sat", 4'd5, {16'd65025, 16'd65025, 16'd65025, 16'd65025, 16'd65025}, 0, 1,
                18'd262143, 1'b1};
    vecs[3] = '{"after_sat", 4'd1, {16'd0, 16'd0, 16'd0, 16'd0, 16'd1}, 0, 0,
                18'd1, 1'b0};
    vecs[4] = '{"zeros", 4'd2, {16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 1, 0,
                18'd0, 1'b0};
    vecs[5] = '{"exact_max", 4'd5, {16'd2043, 16'd65025, 16'd65025, 16'd65025, 16'd65025}, 0, 0,
                18'd262143, 1'b0};
    vecs[6] = '{"one_over", 4'd5, {16'd2044, 16'd65025, 16'd65025, 16'd65025, 16'd65025}, 0, 0,
                18'd262143, 1'b1};

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_acc", 32'(bus.ACC), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
    end

    // len==0 goes straight to DONE with a cleared result.
    bus.start = 1'b1;
    bus.len   = 4'd0;
    tick();
    bus.start = 1'b0;
    chk("len0_out_valid", 32'(bus.out_valid), 32'd1);
    chk("len0_in_ready", 32'(bus.in_ready), 32'd0);
    chk("len0_acc", 32'(bus.ACC), 32'd0);
    chk("len0_ovf", 32'(bus.overflow), 32'd0);
    tick();
    chk("len0_hold_in_ready", 32'(bus.in_ready), 32'd0);
    chk("len0_hold_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("len0_drain", 32'(bus.busy), 32'd0);

    // Reset mid-run abandons partial results.
    bus.start = 1'b1;
    bus.len   = 4'd4;
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.P        = 16'd100;
    tick();
    bus.in_valid = 1'b0;
    chk("midrst_partial", 32'(bus.ACC), 32'd100);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_acc", 32'(bus.ACC), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    tmp = '{"fresh", 4'd1, {16'd0, 16'd0, 16'd0, 16'd0, 16'd7}, 0, 0, 18'd7, 1'b0};
    run_vec(tmp);

    // Reset wins over a simultaneous start.
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.len   = 4'd2;
    tick();
    rst       = 1'b0;
    bus.start = 1'b0;
    chk("rst_prio_busy", 32'(bus.busy), 32'd0);
    chk("rst_prio_acc", 32'(bus.ACC), 32'd0);

    // start during ACCUM is ignored.
    bus.start = 1'b1;
    bus.len   = 4'd2;
    tick();
    bus.start    = 1'b1;
    bus.len      = 4'd1;
    bus.in_valid = 1'b1;
    bus.P        = 16'd10;
    tick();
    chk("ign_mid_valid", 32'(bus.out_valid), 32'd0);
    chk("ign_mid_ready", 32'(bus.in_ready), 32'd1);
    chk("ign_mid_acc", 32'(bus.ACC), 32'd10);
    bus.P = 16'd20;
    tick();
    bus.in_valid = 1'b0;
    chk("ign_done_valid", 32'(bus.out_valid), 32'd1);
    chk("ign_done_acc", 32'(bus.ACC), 32'd30);
    tick();
    chk("ign_done_hold", 32'(bus.ACC), 32'd30);
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("ign_drain", 32'(bus.busy), 32'd0);
    chk("ign_idle_acc", 32'(bus.ACC), 32'd30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_accumulator_8bit.md
MAC_ACCUMULATOR_8BIT -- requirements
Module: mac_accumulator_8bit

Interface
REQ-001 Parameter ACC_W, default 18, accumulator width in bits; legal range 16 to 32.
REQ-002 Parameter LEN_W, default 4, width of the product-count field.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  single-cycle request to begin an accumulation run; sampled only in IDLE.
REQ-006 len  input  LEN_W  number of products in the run; sampled in the same cycle as start.
REQ-007 P  input  16  unsigned product from the upstream 8x8 array multiplier.
REQ-008 in_valid  input  1  P is valid this cycle.
REQ-009 in_ready  output  1  block accepts P this cycle.
REQ-010 ACC  output  ACC_W  accumulated sum, unsigned.
REQ-011 overflow  output  1  sticky flag; the run saturated.
REQ-012 out_valid  output  1  ACC and overflow hold a final result.
REQ-013 out_ready  input  1  downstream consumes the result.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ACCUM, DONE; outputs SHALL decode from registered state only, with no input-to-output combinational path.
REQ-016 IDLE: in_ready=0, out_valid=0; start=1 with len!=0 -> clear ACC and overflow, load remaining<=len, go to ACCUM.
REQ-017 IDLE: start=1 with len==0 -> clear ACC and overflow, go directly to DONE.
REQ-018 start SHALL be ignored in ACCUM and DONE; len SHALL be sampled only with an accepted start.
REQ-019 ACCUM: in_ready=1; a transfer occurs only on a cycle with in_valid=1 and in_ready=1.
REQ-020 Per transfer: ACC <= min(ACC + zero-extended P, 2^ACC_W-1); remaining decrements by 1.
REQ-021 Saturation: if the unsaturated sum exceeds 2^ACC_W-1, set overflow=1; overflow stays set until the next accepted start or rst.
REQ-022 Once saturated, ACC SHALL stay at 2^ACC_W-1 for later transfers.
REQ-023 A transfer with remaining==1 SHALL move the FSM to DONE; out_valid rises on the next cycle, so latency from the last accepted product to result is 1 cycle.
REQ-024 Cycles in ACCUM with in_valid=0 SHALL leave ACC, remaining and overflow unchanged.
REQ-025 DONE: out_valid=1, in_ready=0, and ACC and overflow held stable; out_ready=1 returns the FSM to IDLE, and out_valid drops on the next cycle.
REQ-026 out_valid SHALL remain asserted with no value change for as long as out_ready=0.
REQ-027 In IDLE, ACC and overflow SHALL keep the last result until the next accepted start.
REQ-028 The internal sum SHALL be ACC_W+1 bits wide, so the carry detects overflow without wrap-around.

Reset
REQ-029 On rst=1 at a rising edge: state=IDLE, ACC=0, overflow=0, remaining=0, in_ready=0, out_valid=0, busy=0.
REQ-030 rst SHALL take priority over start, transfers and out_ready in the same cycle.
REQ-031 rst in ACCUM or DONE SHALL abandon the run and discard partial results; the first start after reset SHALL behave as a fresh run.

Verification
REQ-032 rst, then start with len=3 and P=125, 3600, 14450 on consecutive cycles -> ACC=18175, overflow=0, out_valid one cycle after the third transfer.
REQ-033 len=3 with in_valid low for 2 cycles between products, and out_ready held low for 5 cycles in DONE -> ACC=18175, and ACC and out_valid stable through every stall cycle.
REQ-034 len=5 with P=65025 each -> after the 5th transfer ACC=262143 and overflow=1; the next start with len=1 and P=1 -> ACC=1, overflow=0.
REQ-035 start with len=0 -> DONE on the next cycle with ACC=0, overflow=0, and in_ready never high.
REQ-036 len=4, one transfer with P=100, then rst -> next cycle IDLE, ACC=0, busy=0; a fresh start with len=1 and P=7 -> ACC=7.
REQ-037 start pulsed with len=1 during ACCUM of a len=2 run -> ignored; the run completes after 2 transfers with the correct sum.
